// File: rtl/jtag_cmd_regfile.sv
// jtag_cmd_regfile
//   Command decoder and register file behind a word-oriented debug bridge.
//   The block keeps bridge_req raised in RECV until the bridge acks a word. It
//   then decodes the top byte as a command and drops the request for one GAP
//   cycle. Commands write host registers, read one back, send a report burst
//   (header plus snapshot words), or pulse strobes. Sends are serviced through
//   the same request/ack handshake with bridge_wr high.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   bridge_d     word presented to the bridge while sending (registered)
//   bridge_q     word received from the bridge
//   bridge_req   transfer request (registered)
//   bridge_wr    1 = send bridge_d, 0 = receive bridge_q (registered)
//   bridge_ack   one-cycle transfer-complete pulse
//   regs         NREGS packed registers, register i at [i*REGW +: REGW]
//   reg_upd      one-cycle write pulse per register
//   report_in    NREPORT packed report words, word j at [j*32 +: 32]
//   user_strobe  one-cycle pulse on command 0xFD
//   soft_reset   one-cycle pulse on command 0xFF (also clears regs)
//   busy         high while a send sequence is pending

module jtag_cmd_regfile #(
  parameter int unsigned NREGS   = 8,
  parameter int unsigned REGW    = 24,
  parameter int unsigned NREPORT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [31:0]             bridge_d,
  input  logic [31:0]             bridge_q,
  output logic                    bridge_req,
  output logic                    bridge_wr,
  input  logic                    bridge_ack,
  output logic [NREGS*REGW-1:0]   regs,
  output logic [NREGS-1:0]        reg_upd,
  input  logic [NREPORT*32-1:0]   report_in,
  output logic                    user_strobe,
  output logic                    soft_reset,
  output logic                    busy
);

  localparam logic [7:0] CmdReport   = 8'hFE;
  localparam logic [7:0] CmdStrobe   = 8'hFD;
  localparam logic [7:0] CmdSoftRst  = 8'hFF;
  localparam logic [7:0] CmdRbBase   = 8'h80;
  localparam logic [7:0] NReportByte = 8'(NREPORT);

  typedef enum logic [1:0] {StRecv, StGap, StSendHdr, StSendData} state_e;

  state_e           state_q;
  logic             req_q;
  logic             wr_q;
  logic [31:0]      d_q;
  logic [REGW-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] upd_q;
  logic             strobe_q;
  logic             srst_q;
  logic             busy_q;
  // Set when the pending sequence is a report burst rather than a readback.
  logic             rpt_q;
  // Count of words of the current sequence already acked (header counts).
  logic [7:0]       idx_q;
  logic [31:0]      snap_q [NREPORT];
  // Holds the request low for one extra clock after reset release.
  logic             started_q;

  logic [7:0]  cmd;
  logic        rb_hit;
  logic [23:0] rb_val;
  logic [31:0] snap_word;
  logic [7:0]  last_idx;
  logic        unused_q_bits;

  assign cmd           = bridge_q[31:24];
  assign last_idx      = rpt_q ? NReportByte : 8'd0;
  // Payload bits above REGW are simply not stored.
  assign unused_q_bits = ^bridge_q;

  // Readback decode: 0x80+i selects register i, zero-extended to 24 bits.
  always_comb begin
    rb_hit = 1'b0;
    rb_val = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (cmd == CmdRbBase + i[7:0]) begin
        rb_hit             = 1'b1;
        rb_val[REGW-1:0]   = regs_q[i];
      end
    end
  end

  // Next snapshot word to present: after idx_q acked words (header first),
  // the next data word is snapshot entry idx_q.
  always_comb begin
    snap_word = '0;
    for (int unsigned j = 0; j < NREPORT; j++) begin
      if (idx_q == j[7:0]) begin
        snap_word = snap_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRecv;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      d_q       <= '0;
      upd_q     <= '0;
      strobe_q  <= 1'b0;
      srst_q    <= 1'b0;
      busy_q    <= 1'b0;
      rpt_q     <= 1'b0;
      idx_q     <= '0;
      started_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      for (int unsigned j = 0; j < NREPORT; j++) begin
        snap_q[j] <= '0;
      end
    end else begin
      upd_q    <= '0;
      strobe_q <= 1'b0;
      srst_q   <= 1'b0;

      unique case (state_q)
        StRecv: begin
          if (!req_q) begin
            // Only reachable straight after reset: wait one clock, then request.
            if (started_q) begin
              req_q <= 1'b1;
            end else begin
              started_q <= 1'b1;
            end
          end else if (bridge_ack) begin
            req_q   <= 1'b0;
            state_q <= StGap;

            for (int unsigned i = 0; i < NREGS; i++) begin
              if (cmd == i[7:0]) begin
                regs_q[i] <= bridge_q[REGW-1:0];
                upd_q[i]  <= 1'b1;
              end
            end

            if (rb_hit) begin
              d_q    <= {cmd, rb_val};
              busy_q <= 1'b1;
              rpt_q  <= 1'b0;
              idx_q  <= '0;
            end

            if (cmd == CmdReport) begin
              for (int unsigned j = 0; j < NREPORT; j++) begin
                snap_q[j] <= report_in[j*32 +: 32];
              end
              d_q    <= {CmdReport, NReportByte, 16'h0000};
              busy_q <= 1'b1;
              rpt_q  <= 1'b1;
              idx_q  <= '0;
            end

            if (cmd == CmdStrobe) begin
              strobe_q <= 1'b1;
            end

            if (cmd == CmdSoftRst) begin
              srst_q <= 1'b1;
              for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
              end
            end
          end
        end

        StGap: begin
          req_q <= 1'b1;
          if (busy_q) begin
            wr_q    <= 1'b1;
            state_q <= (rpt_q && idx_q == 8'd0) ? StSendHdr : StSendData;
          end else begin
            wr_q    <= 1'b0;
            state_q <= StRecv;
          end
        end

        StSendHdr, StSendData: begin
          if (bridge_ack) begin
            req_q   <= 1'b0;
            state_q <= StGap;
            if (idx_q == last_idx) begin
              busy_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 8'd1;
              d_q   <= snap_word;
            end
          end
        end

        default: state_q <= StRecv;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs[g*REGW +: REGW] = regs_q[g];
  end

  assign bridge_d    = d_q;
  assign bridge_req  = req_q;
  assign bridge_wr   = wr_q;
  assign reg_upd     = upd_q;
  assign user_strobe = strobe_q;
  assign soft_reset  = srst_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_jtag_cmd_regfile.sv
// Scoreboard bench for jtag_cmd_regfile. Stimulus plays the bridge and pushes
// expected send words and expected pulse events into queues; a negedge
// monitor pops and compares whenever the DUT presents them.

module tb_jtag_cmd_regfile;

  localparam int NREGS   = 8;
  localparam int REGW    = 24;
  localparam int NREPORT = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [31:0]           bridge_d;
  logic [31:0]           bridge_q;
  logic                  bridge_req;
  logic                  bridge_wr;
  logic                  bridge_ack;
  logic [NREGS*REGW-1:0] regs;
  logic [NREGS-1:0]      reg_upd;
  logic [NREPORT*32-1:0] report_in;
  logic                  user_strobe;
  logic                  soft_reset;
  logic                  busy;

  always #5 clk = ~clk;

  jtag_cmd_regfile #(
    .NREGS  (NREGS),
    .REGW   (REGW),
    .NREPORT(NREPORT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bridge_d   (bridge_d),
    .bridge_q   (bridge_q),
    .bridge_req (bridge_req),
    .bridge_wr  (bridge_wr),
    .bridge_ack (bridge_ack),
    .regs       (regs),
    .reg_upd    (reg_upd),
    .report_in  (report_in),
    .user_strobe(user_strobe),
    .soft_reset (soft_reset),
    .busy       (busy)
  );

  typedef struct packed {
    logic [7:0]   upd;
    logic         us;
    logic         sr;
    logic [191:0] regs;
  } pulse_t;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [31:0]  exp_tx[$];
  pulse_t       exp_p[$];
  pulse_t       mp;
  logic [191:0] m_regs;
  logic         saw_wr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %s, want %s", name, got, want);
  endtask

  task automatic set_reg(input int i, input logic [23:0] v);
    m_regs[i*24 +: 24] = v;
  endtask

  task automatic push_pulse(input logic [7:0] upd, input logic us, input logic sr);
    pulse_t p;
    p.upd  = upd;
    p.us   = us;
    p.sr   = sr;
    p.regs = m_regs;
    exp_p.push_back(p);
  endtask

  // Bridge delivers one word to the DUT once it requests a receive.
  task automatic rx(input logic [31:0] w);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bridge_req && !bridge_wr) && n < 50);
    if (!(bridge_req && !bridge_wr)) begin
      fail("rx wait", "no receive request", "receive request");
      return;
    end
    bridge_q   = w;
    bridge_ack = 1'b1;
    @(posedge clk); #1;
    bridge_ack = 1'b0;
    check("gap after rx", bridge_req, 1'b0);
  endtask

  // Bridge accepts one send word; the monitor checks its value.
  task automatic tx(input logic last);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bridge_req && bridge_wr) && n < 50);
    if (!(bridge_req && bridge_wr)) begin
      fail("tx wait", "no send request", "send request");
      return;
    end
    bridge_ack = 1'b1;
    @(posedge clk); #1;
    bridge_ack = 1'b0;
    check("gap after tx", bridge_req, 1'b0);
    check("busy after tx", busy, !last);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bridge_req && bridge_wr && bridge_ack) begin
        if (exp_tx.size() == 0) fail("send", "unexpected word", "no send");
        else check("send word", bridge_d, exp_tx.pop_front());
      end
      if (reg_upd != '0 || user_strobe || soft_reset) begin
        if (exp_p.size() == 0) begin
          fail("pulse", "unexpected pulse", "no pulse");
        end else begin
          mp = exp_p.pop_front();
          check("pulse flags", {reg_upd, user_strobe, soft_reset}, {mp.upd, mp.us, mp.sr});
          check("regs at pulse", regs, mp.regs);
        end
      end
    end
  end

  initial begin
    #200000;
    fail("watchdog", "timeout", "finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    bridge_q   = '0;
    bridge_ack = 1'b0;
    report_in  = {32'hBBBBBBBB, 32'hAAAAAAAA};
    m_regs     = '0;
    #1;
    check("reset bridge_req", bridge_req, 1'b0);
    check("reset bridge_wr", bridge_wr, 1'b0);
    check("reset bridge_d", bridge_d, 32'h0);
    check("reset regs", regs, 192'h0);
    check("reset pulses", {reg_upd, user_strobe, soft_reset}, 10'h0);
    check("reset busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("req first clock", bridge_req, 1'b0);
    @(posedge clk); #1;
    check("req second clock", bridge_req, 1'b1);
    check("wr in recv", bridge_wr, 1'b0);

    // Register write
    set_reg(3, 24'h123456);
    push_pulse(8'h08, 1'b0, 1'b0);
    rx(32'h03123456);
    @(posedge clk); #1;
    check("req back after gap", bridge_req, 1'b1);

    // Report burst from snapshot, live input changed after decode
    exp_tx.push_back(32'hFE020000);
    exp_tx.push_back(32'hAAAAAAAA);
    exp_tx.push_back(32'hBBBBBBBB);
    rx(32'hFE000000);
    report_in = {32'hCCCCCCCC, 32'hDDDDDDDD};
    check("busy after report cmd", busy, 1'b1);
    tx(1'b0);
    tx(1'b0);
    tx(1'b1);
    @(posedge clk); #1;
    check("recv after report", {bridge_req, bridge_wr, busy}, 3'b100);

    // Readback
    set_reg(5, 24'hABCDEF);
    push_pulse(8'h20, 1'b0, 1'b0);
    rx(32'h05ABCDEF);
    exp_tx.push_back(32'h85ABCDEF);
    rx(32'h85000000);
    check("busy after readback cmd", busy, 1'b1);
    tx(1'b1);

    // Boundary registers
    set_reg(7, 24'hFFFFFF);
    push_pulse(8'h80, 1'b0, 1'b0);
    rx(32'h07FFFFFF);
    exp_tx.push_back(32'h87FFFFFF);
    rx(32'h87000000);
    tx(1'b1);
    exp_tx.push_back(32'h80000000);
    rx(32'h80000000);
    tx(1'b1);

    // Ignored commands
    rx(32'h40000000);
    rx(32'h08000000);
    rx(32'h88000000);
    @(posedge clk); #1;
    check("regs after ignored", regs, m_regs);
    check("no send after ignored", {bridge_req, bridge_wr, busy}, 3'b100);

    // Soft reset then user strobe
    m_regs = '0;
    push_pulse(8'h00, 1'b0, 1'b1);
    rx(32'hFF000000);
    push_pulse(8'h00, 1'b1, 1'b0);
    rx(32'hFD000000);

    set_reg(1, 24'h000055);
    push_pulse(8'h02, 1'b0, 1'b0);
    rx(32'h01000055);

    // Async reset mid-report after the header ack
    report_in = {32'h11111111, 32'h22222222};
    exp_tx.push_back(32'hFE020000);
    rx(32'hFE000000);
    tx(1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("mid reset req/wr/busy", {bridge_req, bridge_wr, busy}, 3'b000);
    check("mid reset bridge_d", bridge_d, 32'h0);
    check("mid reset regs", regs, 192'h0);
    m_regs = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("req first clock again", bridge_req, 1'b0);
    @(posedge clk); #1;
    check("recv after reset", {bridge_req, bridge_wr}, 2'b10);
    saw_wr = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bridge_wr || busy) saw_wr = 1'b1;
    end
    check("no residual send", saw_wr, 1'b0);

    set_reg(2, 24'h000042);
    push_pulse(8'h04, 1'b0, 1'b0);
    rx(32'h02000042);
    repeat (2) @(posedge clk);
    #1;

    check("tx queue drained", exp_tx.size(), 0);
    check("pulse queue drained", exp_p.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_regfile.md
JTAG_CMD_REGFILE -- requirements
Module: jtag_cmd_regfile

Interface
REQ-001 Parameters SHALL be as follows.
- NREGS, default 8: number of host-writable registers; legal range 1..64.
- REGW, default 24: width of each register; legal range 1..24.
- NREPORT, default 4: number of 32-bit report words; legal range 1..255.
REQ-002 Ports SHALL be as follows.
- clk, input, 1: sole clock; all logic is on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- bridge_d, output, 32: word sent to the debug bridge.
- bridge_q, input, 32: word received from the debug bridge.
- bridge_req, output, 1: transfer request.
- bridge_wr, output, 1: direction; 1 = send bridge_d, 0 = receive bridge_q.
- bridge_ack, input, 1: one-cycle transfer-complete pulse from the bridge.
- regs, output, NREGS*REGW: register i is at bits [i*REGW +: REGW].
- reg_upd, output, NREGS: one-cycle pulse per register written.
- report_in, input, NREPORT*32: report word j is at bits [j*32 +: 32].
- user_strobe, output, 1: one-cycle pulse on command 0xFD.
- soft_reset, output, 1: one-cycle pulse on command 0xFF.
- busy, output, 1: high while any send is pending.

Function
REQ-003 States SHALL be RECV, GAP, SEND_HDR and SEND_DATA; bridge_req, bridge_wr and bridge_d SHALL be registered.
REQ-004 In RECV the block SHALL drive bridge_req=1 and bridge_wr=0.
REQ-005 bridge_ack sampled high SHALL complete the current transfer; in the next cycle bridge_req SHALL be 0 (GAP state) for exactly one cycle.
REQ-006 bridge_ack while bridge_req=0 SHALL be ignored.
REQ-007 The command byte SHALL be bridge_q[31:24], decoded in the ack cycle, with effects visible in the following cycle.
REQ-008 Command c < NREGS SHALL load regs[c] <= bridge_q[REGW-1:0] and pulse reg_upd[c] for exactly one cycle; all other registers SHALL be unchanged.
REQ-009 Command 0x80+i with i < NREGS SHALL queue a single readback word {8'h80+i, zero-extended regs[i]} sent via SEND_DATA.
REQ-010 Command 0xFE SHALL snapshot all of report_in in the ack cycle, then send a header {8'hFE, NREPORT[7:0], 16'h0000} followed by snapshot words 0..NREPORT-1 in order.
REQ-011 Report words SHALL come from the snapshot, not the live report_in.
REQ-012 Command 0xFD SHALL pulse user_strobe for one cycle.
REQ-013 Command 0xFF SHALL pulse soft_reset for one cycle and clear all regs to 0 in the same cycle, with no reg_upd pulses.
REQ-014 All other command values, including c in NREGS..0x7F and 0x80+i with i >= NREGS, SHALL be ignored; the state returns to RECV via GAP.
REQ-015 In SEND_HDR and SEND_DATA the block SHALL drive bridge_req=1 and bridge_wr=1, and hold bridge_d stable until ack.
REQ-016 After each send ack the block SHALL pass through GAP; the word index SHALL increment, and after the last word the state returns to RECV.
REQ-017 No receive SHALL be accepted while a send sequence is pending.
REQ-018 busy SHALL be high from the cycle after a 0xFE or readback command is decoded until the cycle after the final send ack.
REQ-019 The word index SHALL be 8 bits wide and SHALL NOT wrap; NREPORT=255 SHALL send 256 words in total.
REQ-020 The outputs reg_upd, user_strobe and soft_reset SHALL never be high for more than one consecutive cycle per command.

Reset
REQ-021 reset_n low SHALL immediately force the following values.
- State: RECV.
- Driven to 0: bridge_req, bridge_wr, bridge_d, regs, reg_upd, user_strobe, soft_reset, busy, snapshot and word index.
REQ-022 In the first clock after reset_n deasserts, bridge_req SHALL be 0; it SHALL rise on the second clock.
REQ-023 Reset asserted mid-send SHALL abandon the sequence, with no further words sent after release.
REQ-024 soft_reset SHALL NOT reset this block's state machine; the in-progress GAP/RECV sequence continues.

Verification
REQ-025 Write: NREGS=8, REGW=24; receive 0x03123456 -> next cycle regs[3]=0x123456, reg_upd=0x08 for 1 cycle, other regs 0, bridge_req=0 for 1 cycle then 1.
REQ-026 Report: NREPORT=2, report_in={0xBBBBBBBB,0xAAAAAAAA}; receive 0xFE000000, then change report_in -> sends 0xFE020000, 0xAAAAAAAA, 0xBBBBBBBB with bridge_wr=1, then RECV with busy=0.
REQ-027 Readback: write 0x05ABCDEF, then receive 0x85000000 -> single send 0x85ABCDEF.
REQ-028 Ignored commands: receive 0x40000000 and 0x88000000 with NREGS=8 -> no reg change, no pulse, no send.
REQ-029 Soft reset: regs nonzero; receive 0xFF000000 -> soft_reset pulse 1 cycle, all regs 0, reg_upd stays 0; then receive 0xFD000000 -> user_strobe pulse 1 cycle.
REQ-030 Async reset: assert reset_n low mid-report after the header ack -> outputs 0 within the same cycle; after release, bridge_req=0 for 1 cycle, then RECV, and no residual report words are sent.
